// File: rtl/sd_crc_pkg.sv
// Shared state type and CRC constants for the SD multi-lane CRC engine.
package sd_crc_pkg;

   typedef enum logic [1:0] {
      CALC  = 2'd0,
      SHIFT = 2'd1,
      CHECK = 2'd2
   } crc_state_t;

   localparam int unsigned CRC16_W = 16;
   localparam int unsigned CRC7_W  = 7;
   localparam logic [CRC16_W-1:0] CRC16_POLY = 16'h1021;
   localparam logic [CRC7_W-1:0]  CRC7_POLY  = 7'h09;

endpackage

// File: rtl/sd_crc_lanes_lane.sv
// One bit-serial MSB-first CRC LFSR with load-init, zero-fill shift and data update.
module crc_lane
   import sd_crc_pkg::*;
#(
   parameter int unsigned      CRC_W = CRC16_W,
   parameter logic [CRC_W-1:0] POLY  = CRC16_POLY,
   parameter logic [CRC_W-1:0] INIT  = '0
) (
   input  logic             iclk,
   input  logic             irst,
   input  logic             iload_init,
   input  logic             ishift,
   input  logic             iupdate,
   input  logic             idata,
   output logic [CRC_W-1:0] ocrc
);

   logic [CRC_W-1:0] crc_q, crc_d;
   logic             fb;

   always_comb begin
      crc_d = crc_q;
      fb    = idata ^ crc_q[CRC_W-1];
      if (iload_init)
         crc_d = INIT;
      else if (ishift)
         crc_d = {crc_q[CRC_W-2:0], 1'b0};
      else if (iupdate)
         crc_d = {crc_q[CRC_W-2:0], 1'b0} ^ (fb ? POLY : '0);
   end

   always_ff @(posedge iclk) begin
      if (irst) crc_q <= INIT;
      else      crc_q <= crc_d;
   end

   assign ocrc = crc_q;

endmodule

// File: rtl/sd_crc_lanes.sv
// Multi-lane SD CRC engine: accumulate, serialise out, or check received CRCs.
module sd_crc_lanes
   import sd_crc_pkg::*;
#(
   parameter int unsigned      LANES = 4,
   parameter int unsigned      CRC_W = CRC16_W,
   parameter logic [CRC_W-1:0] POLY  = CRC16_POLY,
   parameter logic [CRC_W-1:0] INIT  = '0
) (
   input  logic                   iclk,
   input  logic                   irst,
   input  logic                   iclr,
   input  logic                   ivalid,
   input  logic [LANES-1:0]       idata,
   input  logic                   istart_out,
   input  logic                   icheck,
   output logic [LANES*CRC_W-1:0] ocrc,
   output logic [LANES-1:0]       ocrc_bit,
   output logic                   ocrc_valid,
   output logic                   ocrc_done,
   output logic                   ocheck_done,
   output logic                   ocrc_ok,
   output logic [LANES-1:0]       olane_err
);

   localparam int unsigned      CNT_W   = $clog2(CRC_W);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CRC_W - 1);

   crc_state_t       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [LANES-1:0] crc_bit_q, crc_bit_d;
   logic             crc_valid_q, crc_valid_d;
   logic             crc_done_q, crc_done_d;
   logic             check_done_q, check_done_d;
   logic             crc_ok_q, crc_ok_d;
   logic [LANES-1:0] lane_err_q, lane_err_d;

   logic                   lane_init, lane_shift, lane_upd;
   logic [LANES*CRC_W-1:0] crc_all;
   logic [LANES-1:0]       msb;

   for (genvar g = 0; g < LANES; g++) begin : g_lane
      crc_lane #(
         .CRC_W (CRC_W),
         .POLY  (POLY),
         .INIT  (INIT)
      ) u_lane (
         .iclk       (iclk),
         .irst       (irst),
         .iload_init (lane_init),
         .ishift     (lane_shift),
         .iupdate    (lane_upd),
         .idata      (idata[g]),
         .ocrc       (crc_all[g*CRC_W +: CRC_W])
      );
   end

   always_comb begin
      msb = '0;
      for (int unsigned i = 0; i < LANES; i++)
         msb[i] = crc_all[i*CRC_W + CRC_W - 1];
   end

   // The start edge already emits the first bit and shifts, so SHIFT covers the
   // remaining CRC_W-1 bits and its cnt==0 cycle is the done/reload cycle.
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      crc_bit_d    = '0;
      crc_valid_d  = 1'b0;
      crc_done_d   = 1'b0;
      check_done_d = 1'b0;
      crc_ok_d     = crc_ok_q;
      lane_err_d   = lane_err_q;
      lane_init    = 1'b0;
      lane_shift   = 1'b0;
      lane_upd     = 1'b0;
      if (iclr) begin
         state_d    = CALC;
         cnt_d      = '0;
         crc_ok_d   = 1'b0;
         lane_err_d = '0;
         lane_init  = 1'b1;
      end else begin
         case (state_q)
            CALC: begin
               if (istart_out) begin
                  state_d     = SHIFT;
                  cnt_d       = CNT_MAX;
                  crc_bit_d   = msb;
                  crc_valid_d = 1'b1;
                  lane_shift  = 1'b1;
               end else if (icheck) begin
                  state_d    = CHECK;
                  cnt_d      = CNT_MAX;
                  crc_ok_d   = 1'b0;
                  lane_err_d = '0;
               end else if (ivalid) begin
                  lane_upd = 1'b1;
               end
            end
            SHIFT: begin
               if (cnt_q == '0) begin
                  state_d    = CALC;
                  crc_done_d = 1'b1;
                  lane_init  = 1'b1;
               end else begin
                  crc_bit_d   = msb;
                  crc_valid_d = 1'b1;
                  lane_shift  = 1'b1;
                  cnt_d       = cnt_q - CNT_W'(1);
               end
            end
            CHECK: begin
               if (ivalid) begin
                  lane_err_d = lane_err_q | (idata ^ msb);
                  if (cnt_q == '0) begin
                     state_d      = CALC;
                     check_done_d = 1'b1;
                     crc_ok_d     = ~|lane_err_d;
                     lane_init    = 1'b1;
                  end else begin
                     lane_shift = 1'b1;
                     cnt_d      = cnt_q - CNT_W'(1);
                  end
               end
            end
            default: state_d = CALC;
         endcase
      end
   end

   always_ff @(posedge iclk) begin
      if (irst) begin
         state_q      <= CALC;
         cnt_q        <= '0;
         crc_bit_q    <= '0;
         crc_valid_q  <= 1'b0;
         crc_done_q   <= 1'b0;
         check_done_q <= 1'b0;
         crc_ok_q     <= 1'b0;
         lane_err_q   <= '0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         crc_bit_q    <= crc_bit_d;
         crc_valid_q  <= crc_valid_d;
         crc_done_q   <= crc_done_d;
         check_done_q <= check_done_d;
         crc_ok_q     <= crc_ok_d;
         lane_err_q   <= lane_err_d;
      end
   end

   assign ocrc        = crc_all;
   assign ocrc_bit    = crc_bit_q;
   assign ocrc_valid  = crc_valid_q;
   assign ocrc_done   = crc_done_q;
   assign ocheck_done = check_done_q;
   assign ocrc_ok     = crc_ok_q;
   assign olane_err   = lane_err_q;

endmodule
